// File: rtl/adc_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_sequencer_if
//  Description : Bus between the ADC frame sequencer and the ADC / sample
//                consumer. Requests and serial data in, frame strobes and
//                captured samples out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_frame_sequencer_if #(
    parameter int DW = 12
);
    logic          en;
    logic          trig;
    logic          mosi;
    logic          cs_n;
    logic          sck;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          err_o;
    logic          busy_o;

    // Sequencer side
    modport master (
        input  en, trig, mosi,
        output cs_n, sck, data_o, valid_o, err_o, busy_o
    );

    // ADC / consumer side
    modport slave (
        output en, trig, mosi,
        input  cs_n, sck, data_o, valid_o, err_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_sequencer
//  Description : Generates the ADC serial frame (cs_n, sck = clk/2) and
//                captures the 14-bit conversion word (2 leading zeros + 12
//                data bits, MSB first). Free-running at a fixed period while
//                en=1, or single-shot on trig while en=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_sequencer #(
    parameter int SPI_DW        = 14,
    parameter int PERIOD_CYCLES = 50
) (
    input  wire logic             clk,
    input  wire logic             rst,
    adc_frame_sequencer_if.master bus
);

    localparam int c_DW    = SPI_DW - 2;
    localparam int c_BIT_W = $clog2(SPI_DW);
    localparam int c_PER_W = $clog2(PERIOD_CYCLES);

    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(SPI_DW - 1);
    localparam logic [c_PER_W-1:0] c_LAST_PER = c_PER_W'(PERIOD_CYCLES - 1);

    // The frame (28 cycles with cs_n low) plus the frame-end cycle must fit
    // inside one sample period.
    generate
        if (PERIOD_CYCLES < 32) begin : g_period_check
            $error("adc_frame_sequencer: PERIOD_CYCLES must be >= 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CS_SETUP = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_QUIET    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_cs_n;
    logic                r_sck;
    logic [SPI_DW-1:0]   r_shift;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_PER_W-1:0]  r_period;
    logic [c_DW-1:0]     r_data;
    logic                r_valid;
    logic                r_err;

    state_t              w_state_nxt;
    logic                w_cs_n_nxt;
    logic                w_sck_nxt;
    logic [SPI_DW-1:0]   w_shift_nxt;
    logic [c_BIT_W-1:0]  w_bit_cnt_nxt;
    logic [c_PER_W-1:0]  w_period_nxt;
    logic [c_DW-1:0]     w_data_nxt;
    logic                w_valid_nxt;
    logic                w_err_nxt;

    // Next-state and next-output logic; all outputs are registered so that
    // cs_n/sck leave the block glitch-free. The period counter holds the
    // offset from the current frame's cs_n falling edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_cs_n_nxt    = r_cs_n;
        w_sck_nxt     = r_sck;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_period_nxt  = r_period;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = r_err;

        case (r_state)
            ST_IDLE: begin
                w_cs_n_nxt = 1'b1;
                w_sck_nxt  = 1'b1;
                // en has priority; en together with trig still starts one frame
                if (bus.en || bus.trig) begin
                    w_state_nxt   = ST_CS_SETUP;
                    w_cs_n_nxt    = 1'b0;
                    w_period_nxt  = '0;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                end
            end

            ST_CS_SETUP: begin
                w_state_nxt  = ST_SHIFT;
                w_sck_nxt    = 1'b0;
                w_period_nxt = r_period + 1'b1;
            end

            ST_SHIFT: begin
                w_period_nxt = r_period + 1'b1;
                if (!r_sck) begin
                    // This edge drives sck 0->1: capture the bit the ADC
                    // launched on the preceding falling edge.
                    w_shift_nxt   = {r_shift[SPI_DW-2:0], bus.mosi};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_sck_nxt     = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = ST_QUIET;
                        w_cs_n_nxt  = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_shift_nxt[c_DW-1:0];
                        w_err_nxt   = |w_shift_nxt[SPI_DW-1:c_DW];
                    end
                end else begin
                    w_sck_nxt = 1'b0;
                end
            end

            ST_QUIET: begin
                w_cs_n_nxt = 1'b1;
                w_sck_nxt  = 1'b1;
                if (r_period == c_LAST_PER) begin
                    if (bus.en) begin
                        w_state_nxt   = ST_CS_SETUP;
                        w_cs_n_nxt    = 1'b0;
                        w_period_nxt  = '0;
                        w_bit_cnt_nxt = '0;
                        w_shift_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_period_nxt = r_period + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cs_n_nxt  = 1'b1;
                w_sck_nxt   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cs_n    <= 1'b1;
            r_sck     <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_period  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_sck     <= w_sck_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_period  <= w_period_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.cs_n    = r_cs_n;
    assign bus.sck     = r_sck;
    assign bus.data_o  = r_data;
    assign bus.valid_o = r_valid;
    assign bus.err_o   = r_err;
    assign bus.busy_o  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_frame_sequencer
//  Description : Self-checking bench for adc_frame_sequencer. An ADC model
//                serialises queued words; a monitor checks every valid_o
//                against a scoreboard of hand-computed samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_sequencer;

    typedef struct packed {
        logic [11:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t        exp_q[$];
    logic [13:0] adc_q[$];
    int          t0_q[$];

    adc_frame_sequencer_if #(.DW(12)) bus ();

    adc_frame_sequencer #(
        .SPI_DW        (14),
        .PERIOD_CYCLES (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 175 MHz nominal; exact period is irrelevant to cycle-based checks
    always #5 clk = ~clk;

    // Cycle index: stable when sampled on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [13:0] word, input logic [11:0] data, input logic err);
        exp_t e;
        e.data = data;
        e.err  = err;
        adc_q.push_back(word);
        exp_q.push_back(e);
    endtask

    task automatic pulse_trig();
        bus.trig = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.valid_o && n < budget);
        if (!bus.valid_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid: no valid_o within %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy_o && n < budget);
        if (bus.busy_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: busy_o still high after %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    task automatic wait_cs_low(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.cs_n && n < budget);
        if (bus.cs_n) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_cs_low: cs_n never fell within %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    // ADC model: new word on each cs_n fall, one bit per sck falling edge
    logic [13:0] adc_word = '0;
    int          adc_idx  = -1;

    always @(negedge bus.cs_n) begin
        if (adc_q.size() > 0) adc_word = adc_q.pop_front();
        else                  adc_word = '0;
        adc_idx = 13;
    end

    always @(negedge bus.sck) begin
        if (bus.cs_n == 1'b0 && adc_idx >= 0) begin
            bus.mosi = adc_word[adc_idx];
            adc_idx--;
        end
    end

    // Monitor: frame starts, sck edge count, and scoreboard on valid_o
    logic prev_cs_n  = 1'b1;
    logic prev_sck   = 1'b1;
    logic prev_valid = 1'b0;
    int   last_t0    = -1;
    int   rises      = 0;
    int   n_valid    = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_cs_n && !bus.cs_n) begin
                last_t0 = cyc;
                t0_q.push_back(cyc);
                rises = 0;
            end
            if (!prev_sck && bus.sck) rises++;
            if (bus.valid_o) begin
                n_valid++;
                check("valid_single_cycle", 32'(prev_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got data_o=0x%0h, expected no valid_o (cycle %0d)",
                             bus.data_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("data_o", 32'(bus.data_o), 32'(e.data));
                    check("err_o", 32'(bus.err_o), 32'(e.err));
                    check("valid_latency", cyc - last_t0, 32'd28);
                    check("sck_rises", rises, 32'd14);
                end
            end
        end
        prev_cs_n  = bus.cs_n;
        prev_sck   = bus.sck;
        prev_valid = bus.valid_o;
    end

    initial begin
        int t0;
        bus.en   = 1'b0;
        bus.trig = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(bus.cs_n), 32'd1);
        check("rst_sck", 32'(bus.sck), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_data", 32'(bus.data_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;

        // Single-shot frame: trig at cycle 10 -> cs_n low 11..38, valid at 39
        while (cyc < 10) @(negedge clk);
        push_frame(14'b00_1010_0101_1100, 12'hA5C, 1'b0);
        pulse_trig();
        check("t1_cs_n_low", 32'(bus.cs_n), 32'd0);
        check("t1_busy", 32'(bus.busy_o), 32'd1);
        wait_valid(40);
        check("t1_valid_cycle", cyc, 32'd39);
        check("t1_cs_n_high_at_end", 32'(bus.cs_n), 32'd1);
        wait_idle(60);
        check("t1_busy_fall_cycle", cyc, 32'd61);

        // Leading-bit error, held until the next clean frame clears it
        push_frame(14'b01_0000_0000_0001, 12'h001, 1'b1);
        pulse_trig();
        wait_valid(40);
        repeat (5) @(negedge clk);
        check("t2_err_held", 32'(bus.err_o), 32'd1);
        check("t2_data_held", 32'(bus.data_o), 32'h001);
        wait_idle(60);
        push_frame(14'b00_0000_1111_0000, 12'h0F0, 1'b0);
        pulse_trig();
        wait_valid(40);
        check("t2_err_cleared", 32'(bus.err_o), 32'd0);
        wait_idle(60);

        // Continuous mode: five frames, ramp 0..4, starts 50 cycles apart
        t0_q.delete();
        push_frame(14'h0000, 12'h000, 1'b0);
        push_frame(14'h0001, 12'h001, 1'b0);
        push_frame(14'h0002, 12'h002, 1'b0);
        push_frame(14'h0003, 12'h003, 1'b0);
        push_frame(14'h0004, 12'h004, 1'b0);
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) wait_valid(60);
        bus.en = 1'b0;
        wait_idle(60);
        check("t3_frame_count", t0_q.size(), 32'd5);
        for (int i = 1; i < t0_q.size(); i++)
            check("t3_t0_spacing", t0_q[i] - t0_q[i-1], 32'd50);

        // en falls mid-SHIFT: frame completes, no restart at t0+50
        push_frame(14'b00_1100_0011_1010, 12'hC3A, 1'b0);
        bus.en = 1'b1;
        wait_cs_low(5);
        t0 = cyc;
        while (cyc < t0 + 10) @(negedge clk);
        bus.en = 1'b0;
        wait_valid(40);
        check("t4_valid_offset", cyc - t0, 32'd28);
        wait_idle(60);
        check("t4_busy_fall_offset", cyc - t0, 32'd50);
        repeat (5) @(negedge clk);
        check("t4_no_restart", last_t0, t0);
        check("t4_cs_n_idle", 32'(bus.cs_n), 32'd1);

        // trig while busy is ignored; trig in IDLE starts next cycle
        push_frame(14'b00_0101_1010_0101, 12'h5A5, 1'b0);
        pulse_trig();
        t0 = cyc;
        while (cyc < t0 + 5) @(negedge clk);
        pulse_trig();
        wait_valid(40);
        while (cyc < t0 + 40) @(negedge clk);
        pulse_trig();
        wait_idle(60);
        check("t5_busy_fall_offset", cyc - t0, 32'd50);
        repeat (10) @(negedge clk);
        check("t5_no_extra_frame", last_t0, t0);
        check("t5_idle_busy", 32'(bus.busy_o), 32'd0);
        push_frame(14'b00_0011_1100_0011, 12'h3C3, 1'b0);
        pulse_trig();
        check("t5_restart_cs_n", 32'(bus.cs_n), 32'd0);
        wait_valid(40);
        wait_idle(60);

        // Reset held 3 cycles mid-SHIFT aborts the frame
        pulse_trig();
        t0 = cyc;
        while (cyc < t0 + 8) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_cs_n", 32'(bus.cs_n), 32'd1);
        check("t6_sck", 32'(bus.sck), 32'd1);
        check("t6_valid", 32'(bus.valid_o), 32'd0);
        check("t6_data", 32'(bus.data_o), 32'd0);
        check("t6_busy", 32'(bus.busy_o), 32'd0);
        repeat (60) @(negedge clk);

        check("exp_queue_empty", exp_q.size(), 32'd0);
        check("valid_count", n_valid, 32'd11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Generates the ADC serial frame (cs_n, sck) and captures the 14-bit conversion word. It runs on the io clock domain (175 MHz nominal) and produces sck at clk/2 (87.5 MHz). Frames are issued either free-running at a fixed sample period or as single-shot triggers. Each frame yields a 12-bit sample with a valid pulse, which is then handed to the fast-to-slow CDC stage.

Parameters:
SPI_DW, 14, bits per frame: 2 leading zeros followed by 12 data bits, MSB first
DW, 12, output sample width; fixed as SPI_DW-2
PERIOD_CYCLES, 50, clk cycles from one cs_n falling edge to the next in continuous mode (3.5 MSPS at 175 MHz); elaboration error if < 32

Ports:
clk  in  1  io clock
rst  in  1  synchronous reset, active-high
en  in  1  continuous-conversion enable, level
trig  in  1  single-shot request, one-cycle pulse; honoured only when en=0 and the state is IDLE
mosi  in  1  ADC serial data; ADC drives it on the sck falling edge
cs_n  out  1  ADC chip select, active-low, registered
sck  out  1  serial clock, registered, idles high
data_o  out  12  last captured sample, held between frames
valid_o  out  1  one-cycle pulse; data_o and err_o are valid in that cycle
err_o  out  1  frame[13:12] != 0; updated with each valid_o and held until the next one
busy_o  out  1  high from CS_SETUP through QUIET

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE, cs_n=1, sck=1, data_o=0, valid_o=0, err_o=0, busy_o=0, shift register=0, counters=0. rst overrides any in-flight frame immediately; no valid_o is issued for an aborted frame.
- States: IDLE, CS_SETUP, SHIFT, QUIET.
- Timing is relative to t0, the first cycle with cs_n=0.
- IDLE -> CS_SETUP when en=1, or when trig=1 with en=0. The first cs_n=0 cycle is the cycle after the request is sampled.
- CS_SETUP (t0): cs_n=0, sck=1, period counter cleared to 0.
- SHIFT (t0+1 .. t0+27):
  - sck toggles every clk: low at odd offsets, high at even offsets.
  - mosi is sampled at the clk edge that drives sck 0->1, i.e. the end of cycles t0+2k-1, k=1..14.
  - Sampled bits shift left into a 14-bit register (first sample lands in bit 13 after 14 shifts).
  - A 4-bit rising-edge counter advances on each sample; the state exits after the 14th sample.
- Frame end (t0+28): cs_n=1, sck=1, valid_o=1.
  - data_o = shift[11:0].
  - err_o = |shift[13:12].
  - Enter QUIET.
- Latency from cs_n falling to valid_o is 28 cycles.
- QUIET: cs_n=1, sck=1, period counter increments each cycle.
  - Continuous mode: when the counter reaches PERIOD_CYCLES-1 and en=1, go to CS_SETUP. The next t0 is exactly PERIOD_CYCLES after the previous t0.
  - If en=0 at that point, go to IDLE.
  - Single-shot frames (en=0) leave QUIET after the same period, to guarantee the ADC quiet time, then go to IDLE.
- en deasserted mid-frame: the frame completes normally (valid_o issued), then the block returns to IDLE at the end of QUIET.
- en asserted during a single-shot frame: continuous mode continues seamlessly from the end of QUIET.
- trig while busy_o=1 or while en=1: ignored; no queueing.
- en and trig asserted together in IDLE: treated as continuous; one frame starts, not two.
- valid_o is never high for two consecutive cycles. Minimum spacing between valid_o pulses is PERIOD_CYCLES.
- sck never glitches: every high and low phase lasts at least one full clk cycle, including the transitions between states.

Test Plan:
- Reset check: rst held 3 cycles mid-SHIFT -> next cycle shows cs_n=1, sck=1, valid_o=0, data_o=0, busy_o=0; no valid_o afterwards while en=0.
- Single frame: en=0, trig pulse at cycle 10, ADC model drives 14'b00_1010_0101_1100 -> cs_n low cycles 11..38, exactly 14 sck rising edges, valid_o at cycle 39 with data_o=12'hA5C and err_o=0.
- Leading-bit error: ADC model drives 14'b01_0000_0000_0001 -> data_o=12'h001, err_o=1 held until the next valid_o; the following clean frame clears it.
- Continuous mode: en=1 for 5 frames with a ramp of 0x000..0x004 -> cs_n falling edges exactly 50 cycles apart, five valid_o pulses with data_o 0x000..0x004 in order.
- en drop mid-SHIFT: en falls at t0+10 -> valid_o still at t0+28, no cs_n fall at t0+50, busy_o falls at t0+50.
- Ignored requests: trig pulsed at t0+5 and t0+40 during a single-shot frame -> only one frame and one valid_o; a trig after returning to IDLE starts a new frame next cycle.
